// File: rtl/multi_tick_gen.sv
// ============================================================================
// Module   : multi_tick_gen
// Purpose  : NCH independent modulus tick counters with runtime period load,
//            continuous/one-shot mode and start/stop control. Optional phase
//            alignment input enabled by defining MULTI_TICK_SYNC_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module multi_tick_gen #(
  parameter int          WIDTH       = 32,
  parameter int          NCH         = 4,
  parameter int unsigned DEFAULT_MAX = 1000,
  parameter int          CH_W        = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [NCH-1:0]    start,
  input  logic [NCH-1:0]    stop,
  input  logic [NCH-1:0]    oneshot,
  input  logic              ld,
  input  logic [CH_W-1:0]   ld_ch,
  input  logic [WIDTH-1:0]  ld_val,
`ifdef MULTI_TICK_SYNC_EN
  input  logic              sync,
`endif
  output logic [NCH-1:0]    tick,
  output logic [NCH-1:0]    busy
);

  localparam logic [0:0]       C_IDLE       = 1'b0;
  localparam logic [0:0]       C_RUN        = 1'b1;
  localparam logic [WIDTH-1:0] C_RST_PERIOD = WIDTH'(DEFAULT_MAX);

  logic w_sync;

`ifdef MULTI_TICK_SYNC_EN
  assign w_sync = sync;
`else
  assign w_sync = 1'b0;
`endif

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    logic [0:0]       r_state;
    logic             r_mode;
    logic             r_pend;
    logic             r_tick;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_period;
    logic [WIDTH-1:0] r_shadow;

    logic             w_ld_hit;
    logic             w_run;
    logic             w_term;
    logic             w_going_idle;
    logic [WIDTH-1:0] w_last;

    // Channel indices at or above NCH never match any gi, so they are ignored.
    assign w_ld_hit = ld && (ld_ch == CH_W'(gi));
    assign w_run    = (r_state == C_RUN);
    assign w_last   = (r_period > WIDTH'(1)) ? (r_period - WIDTH'(1)) : '0;
    assign w_term   = (r_count == w_last);

    // A load landing on the edge where the channel drops to IDLE must not be
    // left parked in the shadow, since no terminal count would ever commit it.
    assign w_going_idle = stop[gi] ||
                          (w_run && en && w_term && r_mode && !w_sync && !start[gi]);

    always_ff @(posedge clk) begin
      if (rst) begin
        r_state  <= C_IDLE;
        r_mode   <= 1'b0;
        r_pend   <= 1'b0;
        r_tick   <= 1'b0;
        r_count  <= '0;
        r_period <= C_RST_PERIOD;
        r_shadow <= C_RST_PERIOD;
      end else begin
        if (stop[gi]) begin
          r_state <= C_IDLE;
          r_count <= '0;
          r_tick  <= 1'b0;
          if (r_pend) begin
            r_period <= r_shadow;
            r_pend   <= 1'b0;
          end
        end else if (w_sync && w_run) begin
          r_count <= '0;
          r_tick  <= 1'b0;
        end else if (start[gi]) begin
          r_state <= C_RUN;
          r_count <= '0;
          r_mode  <= oneshot[gi];
          r_tick  <= 1'b0;
        end else if (w_run && en) begin
          if (w_term) begin
            r_count <= '0;
            r_tick  <= 1'b1;
            if (r_pend) begin
              r_period <= r_shadow;
              r_pend   <= 1'b0;
            end
            if (r_mode) begin
              r_state <= C_IDLE;
            end
          end else begin
            r_count <= r_count + WIDTH'(1);
            r_tick  <= 1'b0;
          end
        end else begin
          r_tick <= 1'b0;
        end

        if (w_ld_hit) begin
          if (!w_run || w_going_idle) begin
            r_period <= ld_val;
            r_pend   <= 1'b0;
          end else begin
            r_shadow <= ld_val;
            r_pend   <= 1'b1;
          end
        end
      end
    end

    assign tick[gi] = r_tick;
    assign busy[gi] = r_state[0];
  end

endmodule

`default_nettype wire

// File: doc/multi_tick_gen.md
# multi_tick_gen

Parameterised multi-channel tick generator: NCH independent modulus counters, each with a runtime-loadable period, continuous or one-shot mode, and start/stop control. Each channel emits single-clock-pulse `tick` strobes used as clock enables for slower datapath logic (sample-rate strobes, sequencer steps, timeouts) without extra clock domains. Sits beside the system clock at the top of each datapath; replaces fixed-period single-channel tick counters.

## Interface

- `WIDTH`, 32: counter and period width in bits (2..32).
- `NCH`, 4: number of channels (1..16).
- `DEFAULT_MAX`, 1000: period loaded into every channel at reset (100 kHz tick at 100 MHz clk).
- `CH_W`, 2: channel-index width, must satisfy 2^CH_W >= NCH, minimum 1.

- `clk`  in  1  system clock (100 MHz nominal).
- `rst`  in  1  synchronous reset, active-high.
- `en`  in  1  global enable; low freezes all counters and forces all ticks low.
- `start`  in  NCH  per-channel start/restart strobe.
- `stop`  in  NCH  per-channel stop strobe.
- `oneshot`  in  NCH  per-channel mode, sampled on `start`: 1 = one-shot, 0 = continuous.
- `ld`  in  1  period-load strobe.
- `ld_ch`  in  CH_W  channel addressed by `ld`.
- `ld_val`  in  WIDTH  new period value.
- `tick`  out  NCH  registered single-cycle tick per channel.
- `busy`  out  NCH  channel is in RUN.

One clock; reset is synchronous and active-high.

## Operation

- Per channel: `period` (active), `shadow` (pending), `pend` flag, `count`, `mode`, 2-state FSM IDLE/RUN.
- Reset: all channels IDLE, `count`=0, `period`=`shadow`=DEFAULT_MAX, `pend`=0, `tick`=0, `busy`=0.
- IDLE -> RUN on `start[i]`: `count`<=0, `mode`<=`oneshot[i]`.
- RUN, `en`=1: if `count`==eff_period-1 then `count`<=0 and `tick[i]`<=1, else `count`<=`count`+1 and `tick[i]`<=0.
- eff_period = max(`period`,1): period 0 or 1 gives tick every cycle (tick held high in continuous mode).
- One-shot: on the terminal count, tick as above and RUN -> IDLE in the same edge.
- `start[i]` while RUN: restart, `count`<=0, mode re-sampled; no tick that edge.
- `stop[i]`: RUN -> IDLE, `count`<=0, `tick[i]`<=0. `stop` and `start` same cycle: stop wins.
- `ld`: `ld_ch` >= NCH ignored. Target IDLE: `period`<=`ld_val` immediately. Target RUN: `shadow`<=`ld_val`, `pend`<=1; at next terminal count `period`<=`shadow`, `pend`<=0. Repeated loads before wrap: last wins.
- `en`=0: counts, FSM, mode frozen; `tick`<=0; start/stop/ld still processed (not frozen).
- `rst` has priority over every input; reset mid-count discards state, including pending loads.

## Timing

- All outputs registered; no combinational input-to-output path.
- `start` sampled at edge E0: `busy` high after E0; first `tick` high during the cycle after edge E0+P (P = eff_period), then every P cycles.
- One-shot: single tick after E0+P; `busy` low after the same edge.
- Period change on running channel: current interval completes with old P; next interval uses new P.
- `stop` at edge Es: `busy` and `tick` low after Es.
- Wrap-around: `count` never exceeds eff_period-1; WIDTH-bit arithmetic, no overflow path.

## Configuration

- `MULTI_TICK_SYNC_EN`: defined adds input `sync` (1 bit). `sync`=1 at an edge sets `count`<=0 for every RUN channel (phase alignment), `tick`<=0 that edge, lower priority than `rst`/`stop`, higher than `start`-restart (equivalent result). Not defined: port absent, no alignment logic.

## Test plan

- Reset then `start`=4'b0001, `oneshot`=0, defaults: tick[0] pulses every 1000 cycles, first 1000 cycles after start edge; other ticks stay 0.
- Load ch1 `ld_val`=5 while IDLE, start one-shot: exactly one tick 5 cycles after start, `busy[1]` drops same edge, no further ticks over 50 cycles.
- Ch2 running P=10, load 3 at count 4: next tick at count 9 (old period), then ticks every 3 cycles.
- Ch3 P=0 and P=1 continuous: tick[3] high every cycle; `en` low 7 cycles: ticks 0, count frozen, resumes phase exactly.
- `start` and `stop` same cycle on running ch0: channel IDLE, `busy[0]`=0, no tick; `rst` mid-count with pending load: period returns to 1000.
- With `MULTI_TICK_SYNC_EN`: ch0 P=8, ch1 P=8 started 3 cycles apart, pulse `sync`: ticks coincide 8 cycles later and thereafter.
